// File: rtl/axis_pack_pkg.sv
// Shared types and constants for the AXI4-Stream 24-bit pixel packer.
// Provides the byte geometry, the FSM state enum and the keep-mask helper.
package axis_pack_pkg;

  localparam int unsigned BYTES_PER_PIX  = 3;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned PIX_W          = 8 * BYTES_PER_PIX;
  localparam int unsigned WORD_W         = 8 * BYTES_PER_WORD;
  localparam int unsigned KEEP_W         = BYTES_PER_WORD;
  localparam int unsigned CNT_W          = 2;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  // Byte-enable mask with the low cnt bytes set (cnt 0..4).
  function automatic logic [KEEP_W-1:0] keep_from_cnt(input logic [2:0] cnt);
    logic [KEEP_W-1:0] k;
    case (cnt)
      3'd0:    k = 4'b0000;
      3'd1:    k = 4'b0001;
      3'd2:    k = 4'b0011;
      3'd3:    k = 4'b0111;
      default: k = 4'b1111;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single AXI4-Stream output stage: holds one word with keep/last until taken.
// Ports: clk, rst (async, active-high); load/load_data/load_keep/load_last from
// the packer core; ready from downstream; valid/data/keep/last to downstream.
// The core only pulses load when the register is free, so no overwrite check.
module axis_out_reg
  import axis_pack_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic [KEEP_W-1:0] load_keep,
  input  logic              load_last,
  input  logic              ready,
  output logic              valid,
  output logic [WORD_W-1:0] data,
  output logic [KEEP_W-1:0] keep,
  output logic              last
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      keep  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      keep  <= load_keep;
      last  <= load_last;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_pixel_packer.sv
// AXI4-Stream packer: 24-bit RGB pixels in, little-endian byte-contiguous
// 32-bit words out (4 pixels -> 3 words). A frame's trailing partial word is
// flushed with a reduced tkeep and tlast.
// Ports: clk, rst (async, active-high); s_axis_* 24-bit pixel slave;
// m_axis_* 32-bit word master with tkeep/tlast.
// Optional macro AXIS_PACK_STATS_EN adds stat_frames/stat_words counters.
module axis_pixel_packer
  import axis_pack_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH          = 24,
  parameter int unsigned C_M_AXIS_TDATA_WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [PIXEL_WIDTH-1:0]            s_axis_tdata,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast
`ifdef AXIS_PACK_STATS_EN
  ,
  output logic [31:0]                       stat_frames,
  output logic [31:0]                       stat_words
`endif
);

  if (PIXEL_WIDTH != PIX_W) begin : g_bad_pixel_width
    $error("axis_pixel_packer: PIXEL_WIDTH must be 24");
  end
  if (C_M_AXIS_TDATA_WIDTH != WORD_W) begin : g_bad_tdata_width
    $error("axis_pixel_packer: C_M_AXIS_TDATA_WIDTH must be 32");
  end

  state_e             state_q, state_d;
  logic [PIX_W-1:0]   res_q, res_d;
  logic [CNT_W-1:0]   res_cnt_q, res_cnt_d;
  logic               out_free;
  logic               accept;
  logic [47:0]        merged;
  logic               load;
  logic [WORD_W-1:0]  load_data;
  logic [KEEP_W-1:0]  load_keep;
  logic               load_last;

  assign out_free      = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = !rst && (state_q == RUN) && out_free;
  assign accept        = s_axis_tvalid && s_axis_tready;

  // New pixel placed directly above the residual bytes; residual upper bytes are kept zero.
  assign merged = (48'(s_axis_tdata) << {res_cnt_q, 3'b000}) | 48'(res_q);

  // State and residual registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      res_q     <= '0;
      res_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      res_q     <= res_d;
      res_cnt_q <= res_cnt_d;
    end
  end

  // Next state: a tlast pixel leaving bytes behind forces one FLUSH word
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:   if (accept && s_axis_tlast && (res_cnt_q >= 2'd2)) state_d = FLUSH;
      FLUSH: if (out_free) state_d = RUN;
    endcase
  end

  // Outputs: output-register load and residual update
  always_comb begin
    load      = 1'b0;
    load_data = '0;
    load_keep = '0;
    load_last = 1'b0;
    res_d     = res_q;
    res_cnt_d = res_cnt_q;
    case (state_q)
      RUN: begin
        if (accept) begin
          if (res_cnt_q == 2'd0) begin
            if (s_axis_tlast) begin
              load      = 1'b1;
              load_data = WORD_W'(s_axis_tdata);
              load_keep = keep_from_cnt(3'd3);
              load_last = 1'b1;
              res_d     = '0;
              res_cnt_d = '0;
            end else begin
              res_d     = PIX_W'(s_axis_tdata);
              res_cnt_d = 2'd3;
            end
          end else begin
            load      = 1'b1;
            load_data = merged[31:0];
            load_keep = keep_from_cnt(3'd4);
            load_last = s_axis_tlast && (res_cnt_q == 2'd1);
            res_d     = PIX_W'(merged[47:32]);
            res_cnt_d = res_cnt_q - 2'd1;
          end
        end
      end
      FLUSH: begin
        if (out_free) begin
          load      = 1'b1;
          load_data = WORD_W'(res_q);
          load_keep = keep_from_cnt(3'(res_cnt_q));
          load_last = 1'b1;
          res_d     = '0;
          res_cnt_d = '0;
        end
      end
    endcase
  end

  axis_out_reg u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (load_data),
    .load_keep (load_keep),
    .load_last (load_last),
    .ready     (m_axis_tready),
    .valid     (m_axis_tvalid),
    .data      (m_axis_tdata),
    .keep      (m_axis_tkeep),
    .last      (m_axis_tlast)
  );

`ifdef AXIS_PACK_STATS_EN
  // Handshake counters, free-running with natural 32-bit wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_frames <= '0;
      stat_words  <= '0;
    end else if (m_axis_tvalid && m_axis_tready) begin
      stat_words <= stat_words + 32'd1;
      if (m_axis_tlast) stat_frames <= stat_frames + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_pixel_packer.sv
// Self-checking bench for axis_pixel_packer: table-driven directed frames,
// a byte-stream model for random backpressure, and a mid-frame reset case.
// With AXIS_PACK_STATS_EN defined it also checks the statistics counters.
module tb_axis_pixel_packer;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } word_t;

  typedef struct {
    logic [23:0] pix;
    logic        last;
    int          n;
    word_t       w0;
    word_t       w1;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tlast;
`ifdef AXIS_PACK_STATS_EN
  logic [31:0] stat_frames;
  logic [31:0] stat_words;
`endif

  int    checks = 0;
  int    failures = 0;
  int    rdy_mode = 0;
  int    words_seen = 0;
  int    tlast_seen = 0;
  int    ready_low = 0;
  bit    count_en = 1'b0;
  bit    stall_prev = 1'b0;
  word_t held;
  word_t exp_q[$];
  logic [7:0] bq[$];
  vec_t  vecs[11];

  always #5 clk = ~clk;

  axis_pixel_packer dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
`ifdef AXIS_PACK_STATS_EN
    ,
    .stat_frames   (stat_frames),
    .stat_words    (stat_words)
`endif
  );

  // Downstream ready pattern: 0 = always ready, 1 = random, other = held low
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = 1'($urandom_range(0, 1));
      default: m_axis_tready = 1'b0;
    endcase
  end

  // Output monitor: scoreboard pop on handshake, hold check under stall
  always @(negedge clk) begin
    word_t cur;
    word_t e;
    cur = '{m_axis_tdata, m_axis_tkeep, m_axis_tlast};
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        if (!m_axis_tvalid || cur !== held) begin
          failures++;
          $display("FAIL hold: got v=%0b d=%h k=%h l=%0b want v=1 d=%h k=%h l=%0b",
                   m_axis_tvalid, cur.d, cur.k, cur.l, held.d, held.k, held.l);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        words_seen++;
        if (m_axis_tlast) tlast_seen++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL word: got unexpected d=%h k=%h l=%0b, want none", cur.d, cur.k, cur.l);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            failures++;
            $display("FAIL word: got d=%h k=%h l=%0b want d=%h k=%h l=%0b",
                     cur.d, cur.k, cur.l, e.d, e.k, e.l);
          end
        end
      end
      if (count_en && !s_axis_tready) ready_low++;
      stall_prev = m_axis_tvalid && !m_axis_tready;
      held = cur;
    end
  end

  function automatic word_t mk(input logic [31:0] d, input logic [3:0] k, input logic l);
    word_t w;
    w.d = d;
    w.k = k;
    w.l = l;
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Byte-level reference: gather bytes, emit full words, flush remainder on tlast
  task automatic model_pixel(input logic [23:0] pix, input logic last);
    logic [31:0] d;
    logic [3:0]  k;
    int          n;
    for (int b = 0; b < 3; b++) bq.push_back(pix[8*b +: 8]);
    while (bq.size() >= 4) begin
      for (int b = 0; b < 4; b++) d[8*b +: 8] = bq.pop_front();
      exp_q.push_back(mk(d, 4'hF, last && bq.size() == 0));
    end
    if (last && bq.size() > 0) begin
      d = '0;
      k = '0;
      n = bq.size();
      for (int b = 0; b < n; b++) begin
        d[8*b +: 8] = bq.pop_front();
        k[b] = 1'b1;
      end
      exp_q.push_back(mk(d, k, 1'b1));
    end
  endtask

  task automatic send_pixel(input logic [23:0] pix, input logic last);
    int  c;
    bit  ok;
    s_axis_tdata  = pix;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    c  = 0;
    ok = 1'b0;
    while (!ok && c < 1000) begin
      @(negedge clk);
      ok = s_axis_tready;
      c++;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got tready=0 for %0d cycles want 1", c);
    end
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic run_vecs(input int first, input int last_idx);
    for (int i = first; i <= last_idx; i++) begin
      if (vecs[i].n >= 1) exp_q.push_back(vecs[i].w0);
      if (vecs[i].n >= 2) exp_q.push_back(vecs[i].w1);
      send_pixel(vecs[i].pix, vecs[i].last);
    end
  endtask

  task automatic drain(input string name);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 5000) begin
      @(posedge clk);
      c++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    word_t z;
    z = mk(32'h0, 4'h0, 1'b0);
    // Scenario 1: four pixels -> three full words
    vecs[0]  = '{24'h221100, 1'b0, 0, z, z};
    vecs[1]  = '{24'h554433, 1'b0, 1, mk(32'h33221100, 4'hF, 1'b0), z};
    vecs[2]  = '{24'h887766, 1'b0, 1, mk(32'h77665544, 4'hF, 1'b0), z};
    vecs[3]  = '{24'hBBAA99, 1'b1, 1, mk(32'hBBAA9988, 4'hF, 1'b1), z};
    // Scenario 2: single-pixel frame -> 3-byte word
    vecs[4]  = '{24'hCCBBAA, 1'b1, 1, mk(32'h00CCBBAA, 4'h7, 1'b1), z};
    // Scenario 3: six pixels -> four full words plus a 2-byte flush
    vecs[5]  = '{24'h020100, 1'b0, 0, z, z};
    vecs[6]  = '{24'h050403, 1'b0, 1, mk(32'h03020100, 4'hF, 1'b0), z};
    vecs[7]  = '{24'h080706, 1'b0, 1, mk(32'h07060504, 4'hF, 1'b0), z};
    vecs[8]  = '{24'h0B0A09, 1'b0, 1, mk(32'h0B0A0908, 4'hF, 1'b0), z};
    vecs[9]  = '{24'h0E0D0C, 1'b0, 0, z, z};
    vecs[10] = '{24'h11100F, 1'b1, 2, mk(32'h0F0E0D0C, 4'hF, 1'b0),
                                      mk(32'h00001110, 4'h3, 1'b1)};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_m_tdata", m_axis_tdata, 32'd0);
    chk("rst_m_tkeep", 32'(m_axis_tkeep), 32'd0);
    chk("rst_m_tlast", 32'(m_axis_tlast), 32'd0);
    chk("rst_s_tready", 32'(s_axis_tready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    ready_low = 0;
    count_en  = 1'b1;
    run_vecs(0, 3);
    drain("s1_drain");
    chk("s1_no_stall", 32'(ready_low), 32'd0);
    count_en = 1'b0;

    run_vecs(4, 4);
    drain("s2_drain");

    ready_low = 0;
    count_en  = 1'b1;
    run_vecs(5, 10);
    drain("s3_drain");
    chk("s3_flush_ready_low", 32'(ready_low), 32'd1);
    count_en = 1'b0;

    // Random backpressure over a 600-pixel frame
    rdy_mode   = 1;
    words_seen = 0;
    tlast_seen = 0;
    for (int i = 0; i < 600; i++) begin
      logic [23:0] p;
      p = 24'($urandom);
      model_pixel(p, i == 599);
      send_pixel(p, i == 599);
    end
    drain("s4_drain");
    chk("s4_words", 32'(words_seen), 32'd450);
    chk("s4_tlast", 32'(tlast_seen), 32'd1);
    rdy_mode = 0;

    // Mid-frame reset with a word stuck in the output register
    rdy_mode = 2;
    @(posedge clk);
    #2;
    send_pixel(24'hDEAD01, 1'b0);
    send_pixel(24'hBEEF02, 1'b0);
    @(negedge clk);
    chk("s5_pre_rst_valid", 32'(m_axis_tvalid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("s5_async_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("s5_async_tready", 32'(s_axis_tready), 32'd0);
    chk("s5_async_tdata", m_axis_tdata, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    rdy_mode = 0;
    @(posedge clk);
    #2;
    run_vecs(0, 3);
    drain("s5_drain");

`ifdef AXIS_PACK_STATS_EN
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 600; i++) begin
        logic [23:0] p;
        p = 24'($urandom);
        model_pixel(p, i == 599);
        send_pixel(p, i == 599);
      end
    end
    drain("s6_drain");
    chk("s6_stat_frames", stat_frames, 32'd2);
    chk("s6_stat_words", stat_words, 32'd900);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
